// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Port IDs, arbitration states and the default geometry live here.
package dmem_arb_pkg;

    localparam int PORT_CPU  = 0;
    localparam int PORT_HOST = 1;

    localparam int DEF_IDX_W    = 8;
    localparam int DEF_MAX_LOCK = 4;

    // Arbitration state names the port that currently wins a tie.
    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } arb_state_e;

    function automatic arb_state_e pri_of(input logic port);
        return port ? PRI1 : PRI0;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational 2-way priority pick: a lone requester always wins,
// a tie goes to the port named by the current arbitration state.
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic       i_req0,
    input  logic       i_req1,
    input  arb_state_e i_state,
    output logic       o_gnt0,
    output logic       o_gnt1
);

    logic w_tie;

    assign w_tie  = i_req0 & i_req1;
    assign o_gnt0 = i_req0 & (~w_tie | (i_state == PRI0));
    assign o_gnt1 = i_req1 & (~w_tie | (i_state == PRI1));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port word-addressed data memory between the CPU MEM stage
// (port 0) and the host loader (port 1) with round-robin and bounded locks.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int IDX_W    = DEF_IDX_W,
    parameter int MAX_LOCK = DEF_MAX_LOCK
)
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic              i_lock0,
    input  logic              i_lock1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [31:0]       i_wdata0,
    input  logic [31:0]       i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_err0,
    output logic              o_err1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [31:0]       o_rdata0,
    output logic [31:0]       o_rdata1,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [31:0]       o_mem_address,
    output logic [31:0]       o_mem_write_data,
    input  logic [31:0]       i_mem_read_data
);

    localparam int               CNT_W      = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(MAX_LOCK);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_lock_cnt;
    logic [CNT_W-1:0] w_lock_cnt_nxt;

    logic             r_rd_pend;
    logic             r_rd_tag;
    logic [31:0]      r_rdata0;
    logic [31:0]      r_rdata1;

    logic             w_pick0;
    logic             w_pick1;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_gnt_any;
    logic             w_sel;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]      w_sel_wdata;
    logic             w_sel_we;
    logic             w_sel_lock;
    logic             w_other_req;
    logic [IDX_W-1:0] w_idx;
    logic             w_misaligned;
    logic             w_out_of_range;
    logic             w_err;
    logic             w_rvalid0;
    logic             w_rvalid1;

    dmem_rr_pick u_pick (
        .i_req0  (i_req0),
        .i_req1  (i_req1),
        .i_state (r_state),
        .o_gnt0  (w_pick0),
        .o_gnt1  (w_pick1)
    );

    // Reset masks every grant so nothing reaches the memory while it is held.
    assign w_gnt0    = w_pick0 & ~i_reset;
    assign w_gnt1    = w_pick1 & ~i_reset;
    assign w_gnt_any = w_gnt0 | w_gnt1;
    assign w_sel     = w_gnt1;

    assign w_sel_addr  = w_sel ? i_addr1  : i_addr0;
    assign w_sel_wdata = w_sel ? i_wdata1 : i_wdata0;
    assign w_sel_we    = w_sel ? i_we1    : i_we0;
    assign w_sel_lock  = w_sel ? i_lock1  : i_lock0;
    assign w_other_req = w_sel ? i_req0   : i_req1;

    assign w_idx          = w_sel_addr[IDX_W+1:2];
    assign w_misaligned   = |w_sel_addr[1:0];
    assign w_out_of_range = |w_sel_addr[ADDR_W-1:IDX_W+2];
    assign w_err          = w_gnt_any & (w_misaligned | w_out_of_range);

    assign o_gnt0 = w_gnt0;
    assign o_gnt1 = w_gnt1;
    assign o_err0 = w_gnt0 & w_err;
    assign o_err1 = w_gnt1 & w_err;

    assign o_mem_read       = w_gnt_any & ~w_sel_we & ~w_err;
    assign o_mem_write      = w_gnt_any &  w_sel_we & ~w_err;
    assign o_mem_address    = w_gnt_any ? {{(32-IDX_W){1'b0}}, w_idx} : 32'd0;
    assign o_mem_write_data = w_gnt_any ? w_sel_wdata : 32'd0;

    // NOTE: every combinational output gets its hold value first, so no path
    // through the block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        if (w_gnt_any) begin
            if (w_sel_lock && w_other_req && (r_lock_cnt < LOCK_LIMIT)) begin
                w_state_nxt    = pri_of(w_sel);
                w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
            end else if (w_sel_lock && !w_other_req) begin
                w_state_nxt    = pri_of(w_sel);
            end else begin
                w_state_nxt    = pri_of(~w_sel);
                w_lock_cnt_nxt = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= PRI0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // Read data passes straight through in the tag's cycle; the hold
    // registers keep the last value so rdata is stable between responses.
    assign w_rvalid0 = r_rd_pend & ~i_reset & (r_rd_tag == 1'(PORT_CPU));
    assign w_rvalid1 = r_rd_pend & ~i_reset & (r_rd_tag == 1'(PORT_HOST));

    assign o_rvalid0 = w_rvalid0;
    assign o_rvalid1 = w_rvalid1;
    assign o_rdata0  = w_rvalid0 ? i_mem_read_data : r_rdata0;
    assign o_rdata1  = w_rvalid1 ? i_mem_read_data : r_rdata1;

    // NOTE: the data hold registers are reset too, because rdata must read 0
    // after reset rather than whatever the flops powered up with.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_pend <= 1'b0;
            r_rd_tag  <= 1'(PORT_CPU);
            r_rdata0  <= 32'd0;
            r_rdata1  <= 32'd0;
        end else begin
            r_rd_pend <= o_mem_read;
            r_rd_tag  <= w_sel;
            if (w_rvalid0) r_rdata0 <= i_mem_read_data;
            if (w_rvalid1) r_rdata1 <= i_mem_read_data;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a spec-level model checked every cycle
// on the falling edge, plus literal expectations at the key points.
module tb_dmem_arbiter;

    localparam int MAXL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, err0, err1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_req0           (req0),
        .i_req1           (req1),
        .i_we0            (we0),
        .i_we1            (we1),
        .i_lock0          (lock0),
        .i_lock1          (lock1),
        .i_addr0          (addr0),
        .i_addr1          (addr1),
        .i_wdata0         (wdata0),
        .i_wdata1         (wdata1),
        .o_gnt0           (gnt0),
        .o_gnt1           (gnt1),
        .o_err0           (err0),
        .o_err1           (err1),
        .o_rvalid0        (rvalid0),
        .o_rvalid1        (rvalid1),
        .o_rdata0         (rdata0),
        .o_rdata1         (rdata1),
        .o_mem_read       (mem_read),
        .o_mem_write      (mem_write),
        .o_mem_address    (mem_address),
        .o_mem_write_data (mem_write_data),
        .i_mem_read_data  (mem_read_data)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory attached to the DUT: registered read, one cycle latency.
    logic [31:0] bmem [256];
    bit          bmem_ready = 1'b0;
    always @(posedge clk) begin
        if (!bmem_ready) begin
            for (int i = 0; i < 256; i++) bmem[i] = init_word(i);
            bmem_ready = 1'b1;
        end
        if (mem_write) bmem[mem_address[7:0]] = mem_write_data;
        if (mem_read)  mem_read_data <= bmem[mem_address[7:0]];
    end

    // Behavioural model: priority port, lock streak, shadow memory, pending read.
    logic [31:0] smem [256];
    bit          smem_ready = 1'b0;
    int          m_prio   = 0;
    int          m_streak = 0;
    bit          m_pend   = 1'b0;
    int          m_tag    = 0;
    logic [31:0] m_pdata  = 32'd0;
    logic [31:0] m_hold [2] = '{32'd0, 32'd0};

    always @(negedge clk) begin : model
        logic [1:0]  rq, wq, lq;
        logic [31:0] aq [2];
        logic [31:0] dq [2];
        logic [31:0] ea, e_addr, e_wd;
        logic        e_err, e_mr, e_mw;
        logic [1:0]  e_rv;
        logic [31:0] e_rd [2];
        int          win, other;

        if (!smem_ready) begin
            for (int i = 0; i < 256; i++) smem[i] = init_word(i);
            smem_ready = 1'b1;
        end
        rq = {req1, req0};
        wq = {we1, we0};
        lq = {lock1, lock0};
        aq[0] = addr0;  aq[1] = addr1;
        dq[0] = wdata0; dq[1] = wdata1;

        if (reset)             win = -1;
        else if (rq == 2'b11)  win = m_prio;
        else if (rq[0])        win = 0;
        else if (rq[1])        win = 1;
        else                   win = -1;

        e_err = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_addr = 32'd0; e_wd = 32'd0;
        if (win >= 0) begin
            ea     = aq[win];
            e_err  = (ea[1:0] != 2'b00) || (ea[31:10] != 22'd0);
            e_addr = {24'd0, ea[9:2]};
            e_wd   = dq[win];
            e_mr   = !wq[win] && !e_err;
            e_mw   =  wq[win] && !e_err;
        end
        for (int p = 0; p < 2; p++) begin
            e_rv[p] = !reset && m_pend && (m_tag == p);
            e_rd[p] = e_rv[p] ? m_pdata : m_hold[p];
        end

        check("gnt0",     {31'd0, gnt0},      {31'd0, win == 0});
        check("gnt1",     {31'd0, gnt1},      {31'd0, win == 1});
        check("err0",     {31'd0, err0},      {31'd0, win == 0 && e_err});
        check("err1",     {31'd0, err1},      {31'd0, win == 1 && e_err});
        check("mem_read", {31'd0, mem_read},  {31'd0, e_mr});
        check("mem_write",{31'd0, mem_write}, {31'd0, e_mw});
        check("mem_addr", mem_address,        e_addr);
        check("mem_wdata",mem_write_data,     e_wd);
        check("rvalid0",  {31'd0, rvalid0},   {31'd0, e_rv[0]});
        check("rvalid1",  {31'd0, rvalid1},   {31'd0, e_rv[1]});
        check("rdata0",   rdata0,             e_rd[0]);
        check("rdata1",   rdata1,             e_rd[1]);

        // Advance to what must hold after the coming rising edge.
        if (reset) begin
            m_prio = 0; m_streak = 0; m_pend = 1'b0;
            m_hold[0] = 32'd0; m_hold[1] = 32'd0;
        end else begin
            for (int p = 0; p < 2; p++) if (e_rv[p]) m_hold[p] = m_pdata;
            m_pend = e_mr;
            if (e_mr) begin
                m_tag   = win;
                m_pdata = smem[e_addr[7:0]];
            end
            if (e_mw) smem[e_addr[7:0]] = e_wd;
            if (win >= 0) begin
                other = 1 - win;
                if (lq[win] && rq[other] && m_streak < MAXL) begin
                    m_prio = win; m_streak++;
                end else if (lq[win] && !rq[other]) begin
                    m_prio = win;
                end else begin
                    m_prio = other; m_streak = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic r, input logic w, input logic l,
                          input logic [31:0] a, input logic [31:0] d);
        req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
    endtask

    task automatic set_p1(input logic r, input logic w, input logic l,
                          input logic [31:0] a, input logic [31:0] d);
        req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
    endtask

    task automatic idle();
        set_p0(0, 0, 0, 32'd0, 32'd0);
        set_p1(0, 0, 0, 32'd0, 32'd0);
    endtask

    logic [12:0] lock1_pat = 13'b0111110111110;
    logic [8:0]  lock0_pat = 9'b111111110;

    initial begin
        reset = 1'b1;
        idle();
        tick();

        // Requests are masked while reset is high.
        set_p0(1, 0, 0, 32'h10, 32'd0);
        #1;
        check("rst_gnt0",  {31'd0, gnt0},     32'd0);
        check("rst_mread", {31'd0, mem_read}, 32'd0);
        tick();
        reset = 1'b0;

        // Lone port 1 in PRI0 is granted; then rotation gives port 0 the tie.
        idle();
        set_p1(1, 1, 0, 32'h44, 32'h1234_5678);
        #1;
        check("lone1_gnt1", {31'd0, gnt1},  32'd1);
        check("lone1_addr", mem_address,    32'd17);
        tick();
        set_p0(1, 1, 0, 32'h10, 32'hDEAD_BEEF);
        set_p1(1, 0, 0, 32'h44, 32'd0);
        #1;
        check("wr_gnt0",  {31'd0, gnt0},      32'd1);
        check("wr_gnt1",  {31'd0, gnt1},      32'd0);
        check("wr_addr",  mem_address,        32'd4);
        check("wr_data",  mem_write_data,     32'hDEAD_BEEF);
        tick();
        set_p1(0, 0, 0, 32'd0, 32'd0);
        set_p0(1, 0, 0, 32'h10, 32'd0);
        #1;
        check("rd_gnt0",  {31'd0, gnt0},      32'd1);
        check("rd_mread", {31'd0, mem_read},  32'd1);
        check("rd_addr",  mem_address,        32'd4);
        tick();
        set_p0(0, 0, 0, 32'd0, 32'd0);
        set_p1(1, 0, 0, 32'h44, 32'd0);
        #1;
        check("raw_rvalid0", {31'd0, rvalid0}, 32'd1);
        check("raw_rdata0",  rdata0,           32'hDEAD_BEEF);
        check("raw_rvalid1", {31'd0, rvalid1}, 32'd0);
        tick();
        idle();
        #1;
        check("h_rvalid1", {31'd0, rvalid1}, 32'd1);
        check("h_rdata1",  rdata1,           32'h1234_5678);
        tick();

        // Unlocked contention alternates 0,1,0,1,0,1.
        for (int i = 0; i < 6; i++) begin
            set_p0(1, 0, 0, 32'h20, 32'd0);
            set_p1(1, 0, 0, 32'h48, 32'd0);
            #1;
            check("alt_gnt0", {31'd0, gnt0}, {31'd0, (i % 2) == 0});
            if (i > 0) check("alt_rvalid0", {31'd0, rvalid0}, {31'd0, (i % 2) == 1});
            tick();
        end
        idle();
        #1;
        check("alt_last_rv1", {31'd0, rvalid1}, 32'd1);
        check("alt_last_rd1", rdata1,           32'hA500_0012);
        tick();

        // lock1 held: one grant to 0, then 5 to port 1, then 0, twice over.
        for (int i = 0; i < 13; i++) begin
            set_p0(1, 0, 0, 32'h24, 32'd0);
            set_p1(1, 0, 1, 32'h4C, 32'd0);
            #1;
            check("lock1_gnt1", {31'd0, gnt1}, {31'd0, lock1_pat[12-i]});
            tick();
        end

        // lock0 with no contender keeps PRI0 without counting.
        for (int i = 0; i < 9; i++) begin
            set_p0(1, 0, 1, 32'h28, 32'd0);
            set_p1(i >= 3, 0, 0, 32'h50, 32'd0);
            #1;
            check("lock0_gnt0", {31'd0, gnt0}, {31'd0, lock0_pat[8-i]});
            tick();
        end
        idle();
        tick();

        // Address errors: misaligned and out of range still consume the grant.
        set_p0(1, 0, 0, 32'h3, 32'd0);
        #1;
        check("mis_gnt0",  {31'd0, gnt0},     32'd1);
        check("mis_err0",  {31'd0, err0},     32'd1);
        check("mis_mread", {31'd0, mem_read}, 32'd0);
        tick();
        set_p0(1, 1, 0, 32'h400, 32'h5);
        #1;
        check("oor_err0",   {31'd0, err0},      32'd1);
        check("oor_mwrite", {31'd0, mem_write}, 32'd0);
        check("mis_no_rv0", {31'd0, rvalid0},   32'd0);
        tick();
        set_p0(1, 0, 0, 32'h3FC, 32'd0);
        set_p1(1, 0, 0, 32'h2, 32'd0);
        #1;
        check("err_rot_gnt1", {31'd0, gnt1},    32'd1);
        check("err1",         {31'd0, err1},    32'd1);
        check("oor_no_rv0",   {31'd0, rvalid0}, 32'd0);
        tick();
        set_p1(0, 0, 0, 32'd0, 32'd0);
        #1;
        check("top_addr", mem_address,       32'd255);
        check("top_err0", {31'd0, err0},     32'd0);
        tick();
        idle();
        #1;
        check("top_rv0", {31'd0, rvalid0}, 32'd1);
        check("top_rd0", rdata0,           32'hA500_00FF);
        tick();

        // Read in flight when reset asserts is dropped; PRI0 afterwards.
        set_p0(1, 0, 0, 32'h10, 32'd0);
        tick();
        reset = 1'b1;
        set_p1(1, 0, 0, 32'h8, 32'd0);
        #1;
        check("rstf_rv0",  {31'd0, rvalid0}, 32'd0);
        check("rstf_gnt0", {31'd0, gnt0},    32'd0);
        check("rstf_gnt1", {31'd0, gnt1},    32'd0);
        tick();
        #1;
        check("rstf_rv0b", {31'd0, rvalid0}, 32'd0);
        check("rstf_rd0",  rdata0,           32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_gnt0", {31'd0, gnt0},    32'd1);
        check("post_rst_rv0",  {31'd0, rvalid0}, 32'd0);
        tick();
        idle();
        #1;
        check("post_rst_rd0", rdata0, 32'hDEAD_BEEF);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port word-addressed data memory between two requesters:
  - port 0, the CPU MEM stage;
  - port 1, the host program/data loader.
- Round-robin arbitration with bounded locked bursts.
- Converts byte addresses to word indices and range-checks them.
- Drives the memory's read/write strobes and routes the 1-cycle-late read data back to the requester that issued the read.

Parameters:
- ADDR_W, 32, requester byte-address width.
- IDX_W, 8, memory word-index width (256 words).
- MAX_LOCK, 4, maximum consecutive locked grants to one port while the other port is waiting.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- req0 / req1  in  1  access request, held until granted.
- we0 / we1  in  1  1 = write, 0 = read.
- lock0 / lock1  in  1  request that this port keeps the grant next cycle.
- addr0 / addr1  in  ADDR_W  byte address.
- wdata0 / wdata1  in  32  write data.
- gnt0 / gnt1  out  1  request accepted this cycle (combinational).
- err0 / err1  out  1  accepted request was misaligned or out of range; access suppressed (same cycle as gnt).
- rvalid0 / rvalid1  out  1  read data valid.
- rdata0 / rdata1  out  32  read data.
- mem_read  out  1  to memory.
- mem_write  out  1  to memory.
- mem_address  out  32  to memory, word index in bits [IDX_W-1:0], upper bits 0.
- mem_write_data  out  32  to memory.
- mem_read_data  in  32  from memory, registered, valid the cycle after mem_read.

Behaviour:
- Reset (checked at posedge):
  - FSM goes to PRI0, lock counter 0, read-tag register invalid.
  - rvalid0/1 = 0, rdata0/1 = 0.
  - While reset is high: gnt0/1, err0/1, mem_read and mem_write are forced to 0.
  - A read in flight when reset asserts is dropped. No rvalid is ever produced for it.
- FSM states:
  - PRI0: port 0 wins ties.
  - PRI1: port 1 wins ties.
  - Exactly one grant per cycle at most. A lone requester is always granted, whatever the state.
- Transitions after a grant to port N:
  - If lockN=1, the other port is requesting and the lock count is below MAX_LOCK: stay in PRI(N) and increment the lock count.
  - If lockN=1 and the other port is not requesting: stay in PRI(N); the lock count is unchanged.
  - Otherwise: move to PRI(other) and clear the lock count.
- Lock limit: once the lock count reaches MAX_LOCK with the other port waiting, the FSM is forced to PRI(other) and the count is cleared.
- No grant in a cycle: state and count hold.
- Address rule: idx = addr[IDX_W+1:2].
  - err is raised if addr[1:0] != 0 or addr[ADDR_W-1:IDX_W+2] != 0.
  - On err: gnt still asserts (the request is consumed), mem_read and mem_write stay 0, and no rvalid follows.
- Memory drive, same cycle as the grant (combinational):
  - mem_read = gnt & ~we & ~err.
  - mem_write = gnt & we & ~err.
  - mem_address and mem_write_data come from the granted port; they are 0 when there is no grant.
- Read return:
  - The granted read's port ID is registered as a tag.
  - The next cycle, rvalid(tag) = 1 and rdata(tag) = mem_read_data.
  - The other port's rvalid is 0.
  - Read latency is exactly 1 cycle. rdata holds its value when rvalid = 0.
- Back-to-back accesses are fully pipelined; one access per cycle is sustained.
  - A write at cycle t followed by a read of the same word at t+1 returns the new data at t+2.
- A write produces no response; gnt is its completion.

Decomposition:
- Package dmem_arb_pkg holds:
  - PORT_CPU = 0, PORT_HOST = 1;
  - FSM state enum {PRI0, PRI1};
  - the default IDX_W and MAX_LOCK constants.
- Sub-module dmem_rr_pick holds the combinational 2-way priority pick. Inputs: req0, req1, state. Outputs: gnt0, gnt1.
- The top module holds the FSM, lock counter, address check, memory mux and response routing.

Test Plan:
- Reset, then req0 write addr 0x10 wdata 0xDEADBEEF; next cycle req0 read addr 0x10 -> gnt0 both cycles; mem_address = 4; rvalid0 = 1 with rdata0 = 0xDEADBEEF two cycles after the write; rvalid1 stays 0.
- req0 and req1 both held on reads for 6 cycles with no lock -> grants alternate 0,1,0,1,0,1; each rvalid arrives 1 cycle after the matching gnt, with the correct tag.
- lock1 = 1, req1 continuous, req0 continuous, MAX_LOCK = 4 -> port 1 granted 5 consecutive cycles (initial grant plus 4 locked), then gnt0; lock count returns to 0.
- req0 read addr 0x3 and, separately, addr 0x400 -> gnt0 = 1, err0 = 1, mem_read = 0, no rvalid0; the FSM still rotates to PRI1.
- Read granted, reset asserted the next cycle -> rvalid0 = 0 during and after reset; gnt0/1 = 0 while reset = 1; FSM is PRI0 afterwards.
- Only req1 active in state PRI0 -> gnt1 the same cycle; state becomes PRI0 afterwards (rotation away from port 1).
